// File: rtl/regfile_clr.sv
// Integer register file with two registered read ports, a0 probe and a clear sequencer.
// Define REGFILE_BYPASS_EN for write-first same-cycle forwarding (read-first otherwise).
module regfile_clr #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PROBE_ADDR    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     busy
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = '1;
  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [AW-1:0] PROBE = AW'(PROBE_ADDR);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic [DW-1:0] a0_q, a0_d;

  logic [DW-1:0] ram [DEPTH];
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;

  logic          wr_ok;
  logic          hit1, hit2, hitp;

  // x0 is never cleared or written, so its storage is masked on every read
  function automatic logic [DW-1:0] pick(
    input logic [AW-1:0] a,
    input logic [DW-1:0] mem,
    input logic          hit,
    input logic [DW-1:0] wd
  );
    if (a == '0) return '0;
    if (hit) return wd;
    return mem;
  endfunction

  assign wr_ok = (state_q == RUN) && !rst && WE3 && (AD3 != '0);
  assign hit1  = BYP && wr_ok && (AD3 == AD1);
  assign hit2  = BYP && wr_ok && (AD3 == AD2);
  assign hitp  = BYP && wr_ok && (AD3 == PROBE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd1_d   = '0;
    rd2_d   = '0;
    a0_d    = '0;
    ram_we  = 1'b0;
    ram_wa  = idx_q;
    ram_wd  = '0;
    if (rst) begin
      state_d = CLEAR;
      idx_d   = ONE;
    end else if (state_q == CLEAR) begin
      ram_we = 1'b1;
      idx_d  = idx_q + ONE;
      if (idx_q == LAST) state_d = RUN;
    end else begin
      rd1_d  = pick(AD1, ram[AD1], hit1, WD3);
      rd2_d  = pick(AD2, ram[AD2], hit2, WD3);
      a0_d   = pick(PROBE, ram[PROBE], hitp, WD3);
      ram_we = wr_ok;
      ram_wa = AD3;
      ram_wd = WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= ONE;
      rd1_q   <= '0;
      rd2_q   <= '0;
      a0_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      a0_q    <= a0_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  assign RD1  = rd1_q;
  assign RD2  = rd2_q;
  assign a0   = a0_q;
  assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_clr.sv
// Scoreboard bench for regfile_clr: directed steps push expectations,
// a monitor pops one per edge and compares.
module tb_regfile_clr;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, a0;
  logic        busy;

  regfile_clr dut (
    .clk(clk), .rst(rst),
    .AD1(AD1), .AD2(AD2), .AD3(AD3),
    .WE3(WE3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .a0(a0),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit [3:0]    m;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] p;
    logic        b;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  localparam bit [3:0] ALL = 4'b1111;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s got %h expected %h", nm, fld, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      if (mon_e.m[0]) chk(mon_e.nm, "RD1", RD1, mon_e.r1);
      if (mon_e.m[1]) chk(mon_e.nm, "RD2", RD2, mon_e.r2);
      if (mon_e.m[2]) chk(mon_e.nm, "a0", a0, mon_e.p);
      if (mon_e.m[3]) chk(mon_e.nm, "busy", {31'b0, busy}, {31'b0, mon_e.b});
    end
  end

  task automatic step(
    input logic r, input logic we,
    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
    input logic [31:0] wd, input string nm, input bit [3:0] m,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic [31:0] ep, input logic eb
  );
    exp_t e;
    rst = r; WE3 = we; AD1 = a1; AD2 = a2; AD3 = a3; WD3 = wd;
    e.nm = nm; e.m = m; e.r1 = e1; e.r2 = e2; e.p = ep; e.b = eb;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic clear_seq(input string nm, input logic we,
                           input logic [4:0] a3, input logic [31:0] wd);
    for (int k = 1; k <= 31; k++)
      step(1'b0, we, 5'd0, 5'd0, a3, wd, nm, ALL, 0, 0, 0, k < 31);
  endtask

  initial begin
    rst = 1'b0; WE3 = 1'b0; AD1 = '0; AD2 = '0; AD3 = '0; WD3 = '0;
    #2;
    step(1, 0, 0, 0, 0, 0, "reset", ALL, 0, 0, 0, 1);
    clear_seq("clear0", 0, 0, 0);

    step(0, 1, 0, 0, 5, 32'hDEADBEEF, "wr_x5", ALL, 0, 0, 0, 0);
    step(0, 0, 5, 5, 0, 0, "rd_x5", ALL, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    step(1, 0, 0, 0, 0, 0, "rst_run", ALL, 0, 0, 0, 1);
    clear_seq("clear1", 0, 0, 0);
    for (int i = 1; i < 32; i++)
      step(0, 0, 5'(i), 5'(32 - i), 0, 0, "rd_zero", ALL, 0, 0, 0, 0);

    step(0, 1, 0, 0, 7, 32'h12345678, "wr_x7", ALL, 0, 0, 0, 0);
    step(0, 0, 7, 7, 0, 0, "rd_x7", ALL, 32'h12345678, 32'h12345678, 0, 0);

    step(0, 1, 0, 0, 0, 32'hFFFFFFFF, "wr_x0", ALL, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, "rd_x0", ALL, 0, 0, 0, 0);

    step(0, 1, 0, 0, 3, 32'h11, "wr_x3a", 4'b1000, 0, 0, 0, 0);
    step(0, 1, 3, 3, 3, 32'h22, "rdw_x3", ALL,
         BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 0, 0);
    step(0, 0, 3, 7, 0, 0, "rd_x3", ALL, 32'h22, 32'h12345678, 0, 0);

    step(0, 1, 10, 0, 10, 32'hA5A5A5A5, "probe_wr", 4'b0101,
         BYP ? 32'hA5A5A5A5 : 32'h0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, 0);
    step(0, 0, 10, 0, 0, 0, "probe", ALL, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);

    step(1, 1, 0, 0, 6, 32'h66, "rst2", ALL, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++)
      step(0, 1, 0, 0, 4, 32'h99, "clr_part", ALL, 0, 0, 0, 1);
    step(1, 1, 0, 0, 4, 32'h99, "rst_mid", ALL, 0, 0, 0, 1);
    clear_seq("clear2", 1, 4, 32'h99);

    step(0, 1, 4, 5, 9, 32'h77, "first_wr", ALL, 0, 0, 0, 0);
    step(0, 0, 9, 10, 0, 0, "rd_x9", ALL, 32'h77, 0, 0, 0);
    step(0, 0, 6, 3, 0, 0, "rd_x6_x3", ALL, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue got %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_clr.md
# regfile_clr

Parametrised successor to the team's integer register file: two registered read ports, one synchronous write port, a registered probe port for a fixed architectural register (default a0/x10), and register x0 hardwired to zero. Adds a synchronous-reset clear sequencer that zeroes every register one entry per cycle, with a `busy` flag. Also adds an optional same-cycle write-to-read bypass. Sits in the CPU datapath between decode (addresses) and the ALU/writeback stage.

## Interface
- `ADDRESS_WIDTH`, 5: register index width; depth = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, 32: register width.
- `PROBE_ADDR`, 10: index driven continuously onto `a0`; must be < depth.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset; synchronous and active-high; starts the clear sequence.
- `AD1` input ADDRESS_WIDTH: read port 1 address.
- `AD2` input ADDRESS_WIDTH: read port 2 address.
- `AD3` input ADDRESS_WIDTH: write address.
- `WE3` input 1: write enable.
- `WD3` input DATA_WIDTH: write data.
- `RD1` output DATA_WIDTH: registered read data, port 1.
- `RD2` output DATA_WIDTH: registered read data, port 2.
- `a0` output DATA_WIDTH: registered contents of register `PROBE_ADDR`.
- `busy` output 1: high while the clear sequence runs; writes are ignored when high.

## Operation
- **States:** CLEAR, RUN. An internal counter `idx` is ADDRESS_WIDTH bits wide.
- **`rst` = 1 at an edge:**
  - State goes to CLEAR and `idx` to 1.
  - `RD1`, `RD2` and `a0` go to 0; `busy` goes to 1.
  - The array is not written on that edge.
- **CLEAR with `rst` = 0:**
  - Each edge writes 0 to `ram[idx]`, then increments `idx`.
  - When `idx` equals depth−1, that edge clears the last entry and the state goes to RUN.
  - `WE3` is ignored.
  - `RD1`, `RD2` and `a0` are held at 0.
- **RUN:**
  - Each edge loads `RD1 <= ram[AD1]`, `RD2 <= ram[AD2]` and `a0 <= ram[PROBE_ADDR]`.
  - If `WE3` = 1 and `AD3` != 0, the edge also writes `ram[AD3] <= WD3`.
- **Register 0:**
  - Never written.
  - Any read of index 0 returns 0, in every state.
- **Read-during-write to the same index:**
  - Without bypass, the read returns the old value.
  - With bypass, see Configuration.
- **`rst` mid-CLEAR:** restarts the sequence at `idx` = 1.
- **`rst` mid-RUN:** aborts operation and enters CLEAR; any write presented on that edge is dropped.
- `AD1`, `AD2` and `AD3` may all be equal; each port resolves independently.

## Timing
- **Read latency:** 1 cycle. Address applied before edge N; data valid after edge N.
- **Write:** visible to a read sampled at edge N+1 or later (no bypass).
- **Clear duration:** depth−1 edges with `rst` low. For ADDRESS_WIDTH = 5 this is 31 edges.
  - `busy` is 1 from the first `rst` edge.
  - `busy` falls after the (depth−1)th `rst`-low edge.
  - The first accepted write is on the following edge.
- **Reset values:** `RD1` = 0, `RD2` = 0, `a0` = 0, `busy` = 1, state = CLEAR, `idx` = 1.
- The array has no per-entry reset. It is zeroed only by the sequencer.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** in RUN, if `WE3` = 1, `AD3` != 0 and `AD3` equals the read index of a port (`AD1`, `AD2` or `PROBE_ADDR`), that port registers `WD3` on the same edge. This is write-first behaviour.
- **`REGFILE_BYPASS_EN` not defined:** that port registers the pre-write array value. This is read-first behaviour.
- Bypass never applies in CLEAR or to index 0.

## Test plan
- **Reset clear:** preload x5 = 0xDEADBEEF, then assert `rst` for 1 edge. Expect `busy` high for exactly 31 `rst`-low edges. Afterwards reads of every index 1–31 return 0.
- **Write/read latency:** write x7 = 0x12345678. Read x7 on the next cycle: `RD1` = 0x12345678 one edge after the address is applied.
- **x0 protection:** write `AD3` = 0, `WD3` = 0xFFFFFFFF. A later read `AD1` = `AD2` = 0 gives `RD1` = `RD2` = 0.
- **Simultaneous read/write:** x3 = 0x11, then write x3 = 0x22 while `AD1` = 3. The next `RD1` is 0x22 with `REGFILE_BYPASS_EN`, 0x11 without. The following cycle reads 0x22 in both builds.
- **Probe:** write x10 = 0xA5A5A5A5 → `a0` = 0xA5A5A5A5 after the next edge with bypass, one edge later without.
- **Reset mid-clear and writes while busy:**
  - Assert `rst` 10 edges into the clear sequence; expect the full 31-edge count again.
  - Issue `WE3` = 1 to x4 = 0x99 while `busy` = 1; expect x4 to read 0 after clear completes.
